// File: rtl/top_proc_pkg.sv
// Shared definitions for the multicycle RV32I-subset core: opcodes, ALU control
// codes, FSM states and the default reset PC.
package top_proc_pkg;

    localparam logic [31:0] DEFAULT_INITIAL_PC = 32'h0040_0000;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SLL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_XOR = 4'b1101
    } aluCtrl_t;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB
    } procState_t;

endpackage

// File: rtl/proc_alu.sv
// 32-bit ALU for the multicycle core. The shifter exists only when
// TOP_PROC_SHIFT_EN is defined; otherwise shift codes produce zero.
module proc_alu
    import top_proc_pkg::*;
(
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [3:0]  ctrl,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = opA & opB;
            ALU_OR:  result = opA | opB;
            ALU_ADD: result = opA + opB;
            ALU_SUB: result = opA - opB;
            ALU_SLT: result = {31'b0, $signed(opA) < $signed(opB)};
            ALU_XOR: result = opA ^ opB;
`ifdef TOP_PROC_SHIFT_EN
            ALU_SRL: result = opA >> opB[4:0];
            ALU_SLL: result = opA << opB[4:0];
            ALU_SRA: result = $signed(opA) >>> opB[4:0];
`endif
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/top_proc_multicycle.sv
// Multicycle RV32I-subset core, five cycles per instruction. Shift instructions
// are decoded only when TOP_PROC_SHIFT_EN is defined, else they retire as NOPs.
//
// state | meaning
// IF    | PC drives ROM; ROM registers instr at end of cycle
// ID    | instr valid; latched into IR at the ID->EX edge
// EX    | ALU evaluates IR operands; MemRead/MemWrite armed for MEM
// MEM   | LW reads / SW writes the data RAM
// WB    | rd written, PC advanced (PC+4 or branch target)
module top_proc_multicycle
    import top_proc_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC = DEFAULT_INITIAL_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dReadData,
    output logic [31:0] PC,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] WriteBackData
);

    procState_t  state;
    logic [31:0] ir;
    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] immI, immS, immB;
    logic [31:0] rs1Val, rs2Val, aluB, aluResult;
    logic [3:0]  aluCtrl;
    logic        aluZero, useImm, regWrite, isLw, isSw, isBeq;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    assign immI = {{20{ir[31]}}, ir[31:20]};
    assign immS = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign immB = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    assign rs1Val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2Val = (rs2 == 5'd0) ? '0 : regs[rs2];

    always_comb begin
        aluCtrl  = ALU_ADD;
        useImm   = 1'b0;
        regWrite = 1'b0;
        isLw     = 1'b0;
        isSw     = 1'b0;
        isBeq    = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                useImm   = (opcode == OP_I);
                regWrite = 1'b1;
                case (funct3)
                    // ir[30] is an immediate bit for ADDI, so SUB exists only in R-type
                    3'b000: aluCtrl = (opcode == OP_R && ir[30]) ? ALU_SUB : ALU_ADD;
                    3'b010: aluCtrl = ALU_SLT;
                    3'b100: aluCtrl = ALU_XOR;
                    3'b110: aluCtrl = ALU_OR;
                    3'b111: aluCtrl = ALU_AND;
`ifdef TOP_PROC_SHIFT_EN
                    3'b001: aluCtrl = ALU_SLL;
                    3'b101: aluCtrl = ir[30] ? ALU_SRA : ALU_SRL;
`endif
                    default: regWrite = 1'b0;
                endcase
            end
            OP_LW: begin
                useImm   = 1'b1;
                regWrite = 1'b1;
                isLw     = 1'b1;
            end
            OP_SW: begin
                useImm = 1'b1;
                isSw   = 1'b1;
            end
            OP_BEQ: begin
                aluCtrl = ALU_SUB;
                isBeq   = 1'b1;
            end
            default: ;
        endcase
    end

    assign aluB = isSw ? immS : (useImm ? immI : rs2Val);

    proc_alu uAlu (
        .opA    (rs1Val),
        .opB    (aluB),
        .ctrl   (aluCtrl),
        .result (aluResult),
        .zero   (aluZero)
    );

    assign dAddress      = aluResult;
    assign dWriteData    = rs2Val;
    assign WriteBackData = isLw ? dReadData : aluResult;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IF;
            PC       <= INITIAL_PC;
            ir       <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IF: state <= S_ID;
                S_ID: begin
                    ir    <= instr;
                    state <= S_EX;
                end
                S_EX: begin
                    MemRead  <= isLw;
                    MemWrite <= isSw;
                    state    <= S_MEM;
                end
                S_MEM: begin
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    state    <= S_WB;
                end
                S_WB: begin
                    if (regWrite && rd != 5'd0) regs[rd] <= WriteBackData;
                    PC    <= (isBeq && aluZero) ? PC + immB : PC + 32'd4;
                    state <= S_IF;
                end
                default: state <= S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_top_proc_multicycle.sv
// Bench for top_proc_multicycle: ROM/RAM models, an instruction-level reference
// model checked every cycle, and literal results for the directed program.
module tb_top_proc_multicycle;

    localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef TOP_PROC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] dReadData = '0;
    logic [31:0] PC, dAddress, dWriteData, WriteBackData;
    logic        MemRead, MemWrite;

    top_proc_multicycle #(.INITIAL_PC(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .dReadData     (dReadData),
        .PC            (PC),
        .dAddress      (dAddress),
        .dWriteData    (dWriteData),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .WriteBackData (WriteBackData)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:127];
    logic [31:0] ram [0:127];

    always @(posedge clk) begin
        instr <= rom[PC[8:2]];
        if (MemWrite) ram[dAddress[8:2]] <= dWriteData;
        dReadData <= ram[dAddress[8:2]];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction
    function automatic logic [31:0] encLw(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    // Instruction-level model: state advances once per retired instruction.
    logic [31:0] mRegs [0:31];
    logic [31:0] mMem  [0:127];
    logic [31:0] mPc;
    logic [31:0] litVal [0:127];
    bit          litOn  [0:127];

    int          phase;
    int          curIdx;
    logic [31:0] curRes, curAddr, curSd, curNext;
    logic [4:0]  curRd;
    bit          curWr, curLw, curSw;

    always @(posedge clk or negedge rst) begin
        if (!rst) phase <= 0;
        else      phase <= (phase == 4) ? 0 : phase + 1;
    end

    task automatic modelDecode();
        logic [31:0] w, a, b, op2, iI, iS, iB;
        w   = rom[mPc[8:2]];
        a   = mRegs[w[19:15]];
        b   = mRegs[w[24:20]];
        iI  = {{20{w[31]}}, w[31:20]};
        iS  = {{20{w[31]}}, w[31:25], w[11:7]};
        iB  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        curIdx  = int'(mPc[8:2]);
        curRd   = w[11:7];
        curWr   = 1'b0;
        curLw   = 1'b0;
        curSw   = 1'b0;
        curRes  = '0;
        curAddr = '0;
        curSd   = '0;
        curNext = mPc + 32'd4;
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            op2   = (w[6:0] == 7'h13) ? iI : b;
            curWr = 1'b1;
            case (w[14:12])
                3'd0: curRes = (w[6:0] == 7'h33 && w[30]) ? a - op2 : a + op2;
                3'd2: curRes = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
                3'd4: curRes = a ^ op2;
                3'd6: curRes = a | op2;
                3'd7: curRes = a & op2;
                3'd1: begin
                    if (SHIFT_EN) curRes = a << op2[4:0];
                    else          curWr = 1'b0;
                end
                3'd5: begin
                    if (!SHIFT_EN)  curWr = 1'b0;
                    else if (w[30]) curRes = $signed(a) >>> op2[4:0];
                    else            curRes = a >> op2[4:0];
                end
                default: curWr = 1'b0;
            endcase
        end else if (w[6:0] == 7'h03) begin
            curLw   = 1'b1;
            curWr   = 1'b1;
            curAddr = a + iI;
            curRes  = mMem[curAddr[8:2]];
        end else if (w[6:0] == 7'h23) begin
            curSw   = 1'b1;
            curAddr = a + iS;
            curSd   = b;
        end else if (w[6:0] == 7'h63) begin
            if (a == b) curNext = mPc + iB;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mRegs[i] = '0;
            mPc = BASE;
            check("reset PC", PC, BASE);
            check("reset MemRead", {31'b0, MemRead}, 32'd0);
            check("reset MemWrite", {31'b0, MemWrite}, 32'd0);
        end else begin
            if (phase == 0) modelDecode();
            check("PC", PC, mPc);
            check("MemRead", {31'b0, MemRead}, {31'b0, (phase == 3) && curLw});
            check("MemWrite", {31'b0, MemWrite}, {31'b0, (phase == 3) && curSw});
            if (phase == 3 && (curLw || curSw)) check("dAddress", dAddress, curAddr);
            if (phase == 3 && curSw) check("dWriteData", dWriteData, curSd);
            if (phase == 4) begin
                if (curWr) check("WriteBackData", WriteBackData, curRes);
                if (litOn[curIdx]) check("literal WriteBackData", WriteBackData, litVal[curIdx]);
                if (curIdx == 8)  check("beq taken target", curNext, BASE + 32'h30);
                if (curIdx == 12) check("beq not-taken target", curNext, BASE + 32'h34);
                if (curWr && curRd != 5'd0) mRegs[curRd] = curRes;
                if (curSw) mMem[curAddr[8:2]] = curSd;
                mPc = curNext;
            end
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < 128; i++) begin
            rom[i] = '0;
            ram[i] = '0;
            mMem[i] = '0;
            litOn[i] = 1'b0;
            litVal[i] = '0;
        end
        ram[4]  = 32'h8000_0000;
        mMem[4] = 32'h8000_0000;

        rom[0]  = encI(12'd5, 5'd0, 3'd0, 5'd1);            // ADDI x1,x0,5
        rom[1]  = encI(12'hFFD, 5'd0, 3'd0, 5'd2);          // ADDI x2,x0,-3
        rom[2]  = encR(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);      // SUB x3,x1,x2
        rom[3]  = encR(7'h00, 5'd1, 5'd2, 3'd2, 5'd4);      // SLT x4,x2,x1
        rom[4]  = encS(12'd8, 5'd1, 5'd0);                  // SW x1,8(x0)
        rom[5]  = encLw(12'd8, 5'd0, 5'd5);                 // LW x5,8(x0)
        rom[6]  = encI(12'd7, 5'd0, 3'd0, 5'd0);            // ADDI x0,x0,7
        rom[7]  = encR(7'h00, 5'd1, 5'd0, 3'd0, 5'd6);      // ADD x6,x0,x1
        rom[8]  = encB(13'd16, 5'd1, 5'd1);                 // BEQ x1,x1,+16
        rom[9]  = encI(12'd99, 5'd0, 3'd0, 5'd10);
        rom[10] = encI(12'd99, 5'd0, 3'd0, 5'd10);
        rom[11] = encI(12'd99, 5'd0, 3'd0, 5'd10);
        rom[12] = encB(13'd8, 5'd2, 5'd1);                  // BEQ x1,x2,+8
        rom[13] = encLw(12'd16, 5'd0, 5'd8);                // LW x8,16(x0)
        rom[14] = encI(12'h404, 5'd8, 3'd5, 5'd7);          // SRAI x7,x8,4
        rom[15] = encR(7'h00, 5'd0, 5'd7, 3'd0, 5'd9);      // ADD x9,x7,x0
        rom[16] = encR(7'h00, 5'd2, 5'd1, 3'd4, 5'd10);     // XOR x10,x1,x2
        rom[17] = encI(12'h030, 5'd1, 3'd6, 5'd11);         // ORI x11,x1,0x30
        rom[18] = encR(7'h00, 5'd1, 5'd2, 3'd7, 5'd12);     // AND x12,x2,x1
        rom[19] = encI(12'hFFC, 5'd2, 3'd2, 5'd13);         // SLTI x13,x2,-4
        rom[20] = encR(7'h00, 5'd1, 5'd8, 3'd5, 5'd14);     // SRL x14,x8,x1
        rom[21] = encR(7'h00, 5'd1, 5'd1, 3'd1, 5'd15);     // SLL x15,x1,x1
        rom[22] = 32'h0000_007F;                            // unsupported opcode
        rom[23] = encR(7'h00, 5'd1, 5'd1, 3'd0, 5'd16);     // ADD x16,x1,x1
        rom[24] = encS(12'd12, 5'd2, 5'd0);                 // SW x2,12(x0)

        litOn[2]  = 1'b1; litVal[2]  = 32'd8;
        litOn[3]  = 1'b1; litVal[3]  = 32'd1;
        litOn[5]  = 1'b1; litVal[5]  = 32'd5;
        litOn[7]  = 1'b1; litVal[7]  = 32'd5;
        litOn[13] = 1'b1; litVal[13] = 32'h8000_0000;
        litOn[16] = 1'b1; litVal[16] = 32'hFFFF_FFF8;
        litOn[17] = 1'b1; litVal[17] = 32'h0000_0035;
        litOn[18] = 1'b1; litVal[18] = 32'd5;
        litOn[19] = 1'b1; litVal[19] = 32'd0;
        litOn[23] = 1'b1; litVal[23] = 32'd10;
`ifdef TOP_PROC_SHIFT_EN
        litOn[14] = 1'b1; litVal[14] = 32'hF800_0000;
        litOn[15] = 1'b1; litVal[15] = 32'hF800_0000;
        litOn[20] = 1'b1; litVal[20] = 32'h0400_0000;
        litOn[21] = 1'b1; litVal[21] = 32'h0000_00A0;
`else
        litOn[15] = 1'b1; litVal[15] = 32'd0;
`endif

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("PC after first instruction", PC, BASE + 32'd4);

        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            #1;
            if (phase == 3 && mPc == BASE + 32'd96) found = 1'b1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait for SW in MEM: got timeout, want MEM of SW at %h", BASE + 32'd96);
        end else begin
            rst = 1'b0;
            #1;
            check("MemWrite drops on async reset", {31'b0, MemWrite}, 32'd0);
            check("PC on async reset", PC, BASE);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("RAM untouched by aborted SW", ram[3], 32'd0);
            @(posedge clk);
            #1 rst = 1'b1;
            repeat (5) @(posedge clk);
            @(negedge clk);
            check("PC after restart", PC, BASE + 32'd4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/top_proc_multicycle.md
Name: top_proc_multicycle

Overview:
- Multicycle 32-bit RV32I-subset processor core.
- Each instruction takes 5 cycles: IF, ID, EX, MEM, WB.
- Fetches from an external synchronous instruction ROM and accesses an external synchronous data RAM. Both memories use the low 9 address bits and have 1-cycle read latency.
- Top-level compute block of the SoC. The memories are instantiated outside it.

Parameters:
- INITIAL_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word from ROM (registered ROM output for current PC).
- dReadData  in  32  data word from RAM (registered RAM output).
- PC  out  32  current program counter, drives ROM address.
- dAddress  out  32  data address, equal to the ALU result.
- dWriteData  out  32  store data, equal to the rs2 register value.
- MemRead  out  1  high during MEM of LW.
- MemWrite  out  1  high during MEM of SW; RAM write enable.
- WriteBackData  out  32  value destined for rd: dReadData for LW, otherwise the ALU result.

Behaviour:
- Reset (rst=0, async):
  - PC=INITIAL_PC, state=IF.
  - All 32 registers = 0.
  - MemRead=MemWrite=0.
  - Instruction register = 0.
- FSM: IF -> ID -> EX -> MEM -> WB -> IF, unconditional, 5 cycles per instruction for every opcode.
- IF: PC stable; the ROM registers instr at the end of IF.
- ID:
  - instr is valid.
  - The instruction register latches instr at the ID->EX edge.
  - Decode, immediate generation and the async register-file read (rs1/rs2) are combinational from the IR.
- EX: ALU computes from the IR operands. dAddress is valid from EX through WB.
- MEM:
  - LW: MemRead=1; the RAM registers dout at the end of MEM.
  - SW: MemWrite=1; the RAM writes dWriteData at the end of MEM.
  - Otherwise both are 0. MemRead and MemWrite are 0 in all other states.
- WB, at the WB->IF edge:
  - rd <= WriteBackData for R-type, I-ALU and LW.
  - No register write for SW, BEQ or unsupported opcodes.
  - Writes to x0 are ignored; x0 always reads 0.
  - PC <= PC+imm_B if BEQ and the ALU zero flag is set, else PC+4.
- Opcodes:
  - 0110011 R: ADD/SUB (funct7[5]), AND, OR, XOR, SLT, SLL, SRL, SRA.
  - 0010011 I: ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - 0000011 LW.
  - 0100011 SW.
  - 1100011 BEQ.
  - Any other opcode is a NOP: PC+4, no writes.
- Immediates, all sign-extended from bit 31:
  - I: imm[11:0]=instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- ALU control, 4 bits: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
  - LW/SW use ADD (rs1+imm). BEQ uses SUB; zero = (result==0).
- Arithmetic:
  - 32-bit wrap-around, no overflow trap.
  - SLT/SLTI signed, result 0 or 1.
  - Shift amount is the low 5 bits of operand B.
  - SRA is arithmetic.
- PC wraps modulo 2^32. No alignment check; the memories ignore the upper address bits.
- Reset asserted mid-instruction aborts it immediately. No partial register write; a RAM write is suppressed because MemWrite drops asynchronously.

Optional Feature:
- TOP_PROC_SHIFT_EN defined: SLL, SRL, SRA, SLLI, SRLI, SRAI supported as above.
- Undefined: the shifter is removed; those encodings execute as NOPs (PC+4, no register write).

Decomposition:
- Shared package top_proc_pkg holds:
  - opcode constants (R, I, LW, SW, BEQ);
  - ALU control codes;
  - FSM state enum (IF, ID, EX, MEM, WB);
  - INITIAL_PC default.
- One natural sub-module: proc_alu (op A, op B, 4-bit ctrl -> result, zero).
- Register file, decoder and FSM stay in the top module.

Test Plan:
- Reset with rst=0, release -> PC=0x00400000, MemRead=MemWrite=0; after 5 cycles PC=0x00400004.
- ADDI x1,x0,5 then ADDI x2,x0,-3; SUB x3,x1,x2 -> WriteBackData=8; SLT x4,x2,x1 -> 1.
- SW x1,8(x0) then LW x5,8(x0) -> MemWrite=1 for one cycle with dAddress=8 and dWriteData=5; later WriteBackData=5 in WB.
- BEQ x1,x1,+16 at PC 0x00400020 -> next PC=0x00400030.
- BEQ with unequal operands -> next PC=PC+4.
- ADDI x0,x0,7 -> x0 still reads 0.
- SRAI of 0x80000000 by 4 -> 0xF8000000 with TOP_PROC_SHIFT_EN; register unchanged without it.
- Assert rst during MEM of SW -> no RAM write; PC back to 0x00400000 and state IF.
